// File: rtl/nibble_loop_sequencer_pkg.sv
// Shared types for the nibble-serial ALU loop and its upstream sequencer.
package nibble_loop_sequencer_pkg;

    typedef enum logic [1:0] {
        ADD   = 2'd0,
        SUB   = 2'd1,
        RSHFT = 2'd2,
        PASS  = 2'd3
    } AluCmd;

    typedef struct packed {
        AluCmd cmd;
        logic  carry_in;
    } AluCtrl;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARM   = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } SeqState;

    localparam int NIBBLES_PER_WORD = 8;

    // The loop advances only while the sequencer is running or draining its last nibble.
    function automatic logic seq_drives_loop(input SeqState s);
        return (s == RUN) || (s == DRAIN);
    endfunction

endpackage

// File: rtl/nibble_loop_sequencer_seq_watchdog.sv
// RUN-cycle watchdog: counts RUN cycles since ARM and flags the cycle the limit is hit.
module seq_watchdog #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_run,
    output logic o_expired
);

    logic [4:0] r_count;

    // Saturating RUN-cycle counter, cleared on every ARM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= 5'd0;
        end else if (i_clear) begin
            r_count <= 5'd0;
        end else if (i_run && (r_count != 5'd31)) begin
            r_count <= r_count + 5'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = i_run && (r_count == 5'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/nibble_loop_sequencer.sv
// Word-level request/response front end for the nibble-serial ALU loop.
// Optional RUN watchdog enabled by defining NIBBLE_SEQ_TIMEOUT_EN.
module nibble_loop_sequencer
    import nibble_loop_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  AluCmd       req_cmd,
    input  logic [31:0] req_word1,
    input  logic [31:0] req_word2,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_result,
    output logic        resp_error,
    output logic        loop_perm,
    output AluCtrl      loop_ctrl,
    output logic [31:0] loop_word1,
    output logic [31:0] loop_word2,
    input  logic        loop_busy,
    input  logic [31:0] loop_result
);

    SeqState     r_state;
    SeqState     w_next_state;
    logic        w_accept;
    logic        w_timeout;
    logic        r_run_first;
    logic        r_req_ready;
    logic        r_resp_valid;
    logic        r_loop_perm;
    logic [31:0] r_resp_result;
    AluCtrl      r_loop_ctrl;
    logic [31:0] r_loop_word1;
    logic [31:0] r_loop_word2;

`ifdef NIBBLE_SEQ_TIMEOUT_EN
    logic w_wd_expired;
    logic r_resp_error;

    seq_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (r_state == ARM),
        .i_run     (r_state == RUN),
        .o_expired (w_wd_expired)
    );

    assign w_timeout = w_wd_expired && loop_busy;

    // Error flag set by an abort and held until the response is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_error <= 1'b0;
        end else if (w_timeout) begin
            r_resp_error <= 1'b1;
        end else if ((r_state == DONE) && resp_ready) begin
            r_resp_error <= 1'b0;
        end else begin
            r_resp_error <= r_resp_error;
        end
    end

    assign resp_error = r_resp_error;
`else
    assign w_timeout  = 1'b0;
    assign resp_error = 1'b0;
`endif

    // Next-state logic; the first RUN cycle never looks at loop_busy.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    w_next_state = ARM;
                    w_accept     = 1'b1;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ARM:   w_next_state = RUN;
            RUN: begin
                if (w_timeout) begin
                    w_next_state = DONE;
                end else if (r_run_first || loop_busy) begin
                    w_next_state = RUN;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            DRAIN: w_next_state = DONE;
            DONE: begin
                if (resp_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // State register and control outputs, decoded from the next state so they are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_run_first  <= 1'b0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_loop_perm  <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_run_first  <= (r_state == ARM);
            r_req_ready  <= (w_next_state == IDLE);
            r_resp_valid <= (w_next_state == DONE);
            r_loop_perm  <= seq_drives_loop(w_next_state);
        end
    end

    // Operand/command latch at accept and result capture at the end of DRAIN.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_loop_ctrl   <= AluCtrl'(3'd0);
            r_loop_word1  <= 32'd0;
            r_loop_word2  <= 32'd0;
            r_resp_result <= 32'd0;
        end else begin
            if (w_accept) begin
                r_loop_ctrl.cmd      <= req_cmd;
                r_loop_ctrl.carry_in <= 1'b0;
                r_loop_word1         <= req_word1;
                r_loop_word2         <= req_word2;
            end
            if (r_state == DRAIN) begin
                r_resp_result <= loop_result;
            end else if (w_timeout) begin
                r_resp_result <= 32'd0;
            end
        end
    end

    assign req_ready   = r_req_ready;
    assign resp_valid  = r_resp_valid;
    assign resp_result = r_resp_result;
    assign loop_perm   = r_loop_perm;
    assign loop_ctrl   = r_loop_ctrl;
    assign loop_word1  = r_loop_word1;
    assign loop_word2  = r_loop_word2;

endmodule
